// File: rtl/cpu_pkg.sv
// Shared EX-stage definitions: ALU op/selector codes, divider states and a
// two's-complement helper used by the divider sign fix-up.
package cpu_pkg;

    localparam logic RstEnable = 1'b1;

    localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider: works on operand magnitudes, one quotient bit
// per cycle, then applies MIPS sign rules (quotient XOR of signs, remainder
// follows the dividend).
module div_unit
    import cpu_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        annul,
    output logic        result_valid,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    div_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rem_q, quo_q, dvs_q, dvd_raw_q;
    logic             neg_quo, neg_rem, zero_div;
    logic [32:0]      diff;
    logic             issue;

    assign issue = start && !annul;
    assign diff  = {rem_q, quo_q[31]} - {1'b0, dvs_q};

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    busy      = 1'b1;
                    state_nxt = (divisor == 32'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (annul)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(DIV_CYCLES - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                result_valid = !annul;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == BUSY)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    // Operands are captured at issue; the partial remainder never exceeds the
    // divisor, so bit 32 of diff is a clean borrow flag.
    always_ff @(posedge clk) begin
        if (state == IDLE && issue) begin
            rem_q     <= 32'd0;
            quo_q     <= neg_if(dividend, signed_op && dividend[31]);
            dvs_q     <= neg_if(divisor, signed_op && divisor[31]);
            dvd_raw_q <= dividend;
            neg_quo   <= signed_op && (dividend[31] ^ divisor[31]);
            neg_rem   <= signed_op && dividend[31];
            zero_div  <= (divisor == 32'd0);
        end else if (state == BUSY) begin
            if (!diff[32]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= {rem_q[30:0], quo_q[31]};
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign quotient  = zero_div ? 32'hFFFF_FFFF : neg_if(quo_q, neg_quo);
    assign remainder = zero_div ? dvd_raw_q     : neg_if(rem_q, neg_rem);

endmodule

// File: rtl/ex.sv
// MIPS32 execute stage: combinational ALU result for write-back/forwarding,
// HI/LO registers fed by MTHI/MTLO, the single-cycle multiplier and the divider.
module ex
    import cpu_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        annul_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o
);

    logic [31:0]        hi, lo;
    logic [31:0]        logic_res, shift_res, move_res;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               is_div, writes_hilo;
    logic               div_valid, div_busy;
    logic [31:0]        div_quo, div_rem;

    assign is_div      = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign writes_hilo = is_div || (aluop_i == EXE_MTHI_OP) || (aluop_i == EXE_MTLO_OP) ||
                         (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);

    assign prod_s = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
    assign prod_u = {32'd0, reg1_i} * {32'd0, reg2_i};

    always_comb begin
        logic_res = 32'd0;
        shift_res = 32'd0;
        move_res  = 32'd0;
        unique case (aluop_i)
            EXE_OR_OP:   logic_res = reg1_i | reg2_i;
            EXE_AND_OP:  logic_res = reg1_i & reg2_i;
            EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
            EXE_SLL_OP:  shift_res = reg2_i << reg1_i[4:0];
            EXE_SRL_OP:  shift_res = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP:  shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            EXE_MFHI_OP: move_res  = hi;
            EXE_MFLO_OP: move_res  = lo;
            default:     ;
        endcase
    end

    always_comb begin
        wd_o    = 5'd0;
        wreg_o  = 1'b0;
        wdata_o = 32'd0;
        if (rst != RstEnable) begin
            wd_o   = wd_i;
            wreg_o = wreg_i && !annul_i && !writes_hilo;
            unique case (alusel_i)
                EXE_RES_LOGIC: wdata_o = logic_res;
                EXE_RES_SHIFT: wdata_o = shift_res;
                EXE_RES_MOVE:  wdata_o = move_res;
                default:       wdata_o = 32'd0;
            endcase
        end
    end

    assign stallreq_o = (rst != RstEnable) && div_busy;

    div_unit #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk          (clk),
        .rst          (rst),
        .start        (is_div),
        .signed_op    (aluop_i == EXE_DIV_OP),
        .dividend     (reg1_i),
        .divisor      (reg2_i),
        .annul        (annul_i),
        .result_valid (div_valid),
        .quotient     (div_quo),
        .remainder    (div_rem),
        .busy         (div_busy)
    );

    // A finishing divide owns HI/LO for its commit cycle.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (!annul_i) begin
            if (div_valid) begin
                hi <= div_rem;
                lo <= div_quo;
            end else begin
                unique case (aluop_i)
                    EXE_MTHI_OP:  hi <= reg1_i;
                    EXE_MTLO_OP:  lo <= reg1_i;
                    EXE_MULT_OP:  {hi, lo} <= $unsigned(prod_s);
                    EXE_MULTU_OP: {hi, lo} <= prod_u;
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex.sv
// Bench for the EX stage: table vectors for ALU ops, directed divide/annul/
// reset sequences, and random ops against an arithmetic HI/LO model.
module tb_ex;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, wreg_i, annul_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic [4:0]  wd_o;
    logic        wreg_o, stallreq_o;
    logic [31:0] wdata_o;

    always #5 clk = ~clk;

    ex dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_o(stallreq_o)
    );

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt[10];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_hi, m_lo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0);
        #1 chk({tag, " hi"}, wdata_o, ehi);
        drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0);
        #1 chk({tag, " lo"}, wdata_o, elo);
    endtask

    // MIPS division semantics from integer arithmetic: truncating quotient,
    // remainder carries the dividend's sign.
    task automatic model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            m_lo = 32'hFFFF_FFFF;
            m_hi = a;
        end else begin
            if (sgn) begin
                sa = $signed(a);
                sb = $signed(b);
            end else begin
                sa = {32'd0, a};
                sb = {32'd0, b};
            end
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall);
        int n;
        drive(sgn ? EXE_DIV_OP : EXE_DIVU_OP, EXE_RES_NOP, a, b);
        wreg_i = 1'b1;
        #1 chk({tag, " wreg"}, 32'(wreg_o), 32'd0);
        n = 0;
        while (stallreq_o && n < 40) begin
            n++;
            cyc();
        end
        chk({tag, " stall cycles"}, 32'(n), 32'(exp_stall));
        cyc();
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, ed, nhi, nlo;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [4:0]  wd;
        logic        wv, an, hw, sgn;
        longint      sa, sb, p;

        vt[0] = '{EXE_OR_OP,  EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF0000, 32'h00FFF0F0};
        vt[1] = '{EXE_SRA_OP, EXE_RES_SHIFT, 32'd4,        32'h80000000, 32'hF8000000};
        vt[2] = '{EXE_SRL_OP, EXE_RES_SHIFT, 32'd4,        32'h80000000, 32'h08000000};
        vt[3] = '{EXE_SLL_OP, EXE_RES_SHIFT, 32'd8,        32'h000000FF, 32'h0000FF00};
        vt[4] = '{EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
        vt[5] = '{EXE_XOR_OP, EXE_RES_LOGIC, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        vt[6] = '{EXE_NOR_OP, EXE_RES_LOGIC, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F};
        vt[7] = '{EXE_NOP_OP, EXE_RES_NOP,   32'h00001234, 32'h00005678, 32'h00000000};
        vt[8] = '{EXE_SRA_OP, EXE_RES_SHIFT, 32'd31,       32'h7FFFFFFF, 32'h00000000};
        vt[9] = '{EXE_SRA_OP, EXE_RES_SHIFT, 32'h24,       32'h80000000, 32'hF8000000};

        // Reset: outputs forced low even with live instructions present.
        rst = 1'b1; annul_i = 1'b0; wreg_i = 1'b1; wd_i = 5'd7;
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF0000);
        #1;
        chk("rst wdata", wdata_o, 32'd0);
        chk("rst wreg", 32'(wreg_o), 32'd0);
        chk("rst wd", 32'(wd_o), 32'd0);
        drive(EXE_DIV_OP, EXE_RES_NOP, 32'd9, 32'd3);
        #1 chk("rst stall", 32'(stallreq_o), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        read_hilo("after reset", 32'd0, 32'd0);

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].op, vt[i].sel, vt[i].a, vt[i].b);
            wd_i = 5'(i + 1); wreg_i = 1'b1;
            #1;
            chk($sformatf("vec%0d wdata", i), wdata_o, vt[i].exp);
            chk($sformatf("vec%0d wreg", i), 32'(wreg_o), 32'd1);
            chk($sformatf("vec%0d wd", i), 32'(wd_o), 32'(i + 1));
            cyc();
        end

        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h1, 32'h2);
        annul_i = 1'b1;
        #1 chk("annul wreg", 32'(wreg_o), 32'd0);
        cyc();
        annul_i = 1'b0;

        drive(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFD, 32'd5);
        #1 chk("mult wreg", 32'(wreg_o), 32'd0);
        cyc();
        m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFF1;
        read_hilo("mult", m_hi, m_lo);

        run_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 33);
        read_hilo("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 33);
        read_hilo("divu 100/7", 32'd2, 32'd14);
        run_div("divu by 0", 1'b0, 32'h1234, 32'd0, 1);
        read_hilo("divu by 0", 32'h1234, 32'hFFFFFFFF);

        // Abort a running divide with annul, then with reset.
        for (int k = 0; k < 2; k++) begin
            drive(EXE_MTHI_OP, EXE_RES_NOP, 32'h55, 32'd0); cyc();
            drive(EXE_MTLO_OP, EXE_RES_NOP, 32'h55, 32'd0); cyc();
            drive(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFFFFF9, 32'd2);
            repeat (10) cyc();
            if (k == 0) annul_i = 1'b1; else rst = 1'b1;
            cyc();
            annul_i = 1'b0; rst = 1'b0;
            drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
            #1 chk($sformatf("abort%0d stall", k), 32'(stallreq_o), 32'd0);
            m_hi = (k == 0) ? 32'h55 : 32'd0;
            m_lo = m_hi;
            read_hilo($sformatf("abort%0d", k), m_hi, m_lo);
            repeat (36) cyc();
            read_hilo($sformatf("abort%0d later", k), m_hi, m_lo);
            cyc();
        end

        for (int i = 0; i < 300; i++) begin
            a = $urandom; b = $urandom;
            wd = 5'($urandom_range(0, 31));
            wv = 1'($urandom_range(0, 1));
            an = ($urandom_range(0, 7) == 0);
            nhi = m_hi; nlo = m_lo; hw = 1'b0; ed = 32'd0;
            op = EXE_NOP_OP; sel = EXE_RES_NOP;
            case ($urandom_range(0, 9))
                0: begin op = EXE_OR_OP;  sel = EXE_RES_LOGIC; ed = a | b; end
                1: begin op = EXE_AND_OP; sel = EXE_RES_LOGIC; ed = a & b; end
                2: begin op = EXE_XOR_OP; sel = EXE_RES_LOGIC; ed = a ^ b; end
                3: begin op = EXE_NOR_OP; sel = EXE_RES_LOGIC; ed = ~(a | b); end
                4: begin op = EXE_SLL_OP; sel = EXE_RES_SHIFT; ed = b << a[4:0]; end
                5: begin op = EXE_SRL_OP; sel = EXE_RES_SHIFT; ed = b >> a[4:0]; end
                6: begin
                    op = EXE_SRA_OP; sel = EXE_RES_SHIFT;
                    ed = (b >> a[4:0]) | (b[31] ? ~(32'hFFFFFFFF >> a[4:0]) : 32'd0);
                end
                7: begin
                    hw = 1'b1;
                    if ($urandom_range(0, 1) == 1) begin op = EXE_MTHI_OP; nhi = a; end
                    else begin op = EXE_MTLO_OP; nlo = a; end
                end
                8: begin
                    hw = 1'b1;
                    if ($urandom_range(0, 1) == 1) begin
                        op = EXE_MULT_OP; sa = $signed(a); sb = $signed(b);
                    end else begin
                        op = EXE_MULTU_OP; sa = {32'd0, a}; sb = {32'd0, b};
                    end
                    p = sa * sb;
                    nhi = p[63:32]; nlo = p[31:0];
                end
                default: begin
                    sel = EXE_RES_MOVE;
                    if ($urandom_range(0, 1) == 1) begin op = EXE_MFHI_OP; ed = m_hi; end
                    else begin op = EXE_MFLO_OP; ed = m_lo; end
                end
            endcase
            if (an) begin nhi = m_hi; nlo = m_lo; end
            drive(op, sel, a, b);
            wd_i = wd; wreg_i = wv; annul_i = an;
            #1;
            if (!an) chk($sformatf("rnd%0d wdata op=%02h", i, op), wdata_o, ed);
            chk($sformatf("rnd%0d wreg", i), 32'(wreg_o), 32'(wv && !an && !hw));
            chk($sformatf("rnd%0d wd", i), 32'(wd_o), 32'(wd));
            cyc();
            annul_i = 1'b0;
            m_hi = nhi; m_lo = nlo;
        end

        for (int i = 0; i < 12; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 9));
                2: b = -32'($urandom_range(1, 9));
                default: b = 32'd0;
            endcase
            run_div($sformatf("rdiv%0d", i), sgn, a, b, (b == 32'd0) ? 1 : 33);
            model_div(sgn, a, b);
            read_hilo($sformatf("rdiv%0d", i), m_hi, m_lo);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
